lsu_ctrl: RTL and testbench
===========================

Name: lsu_ctrl

Overview:
Parametrised load/store unit between the EX/MEM stage and the data memory port, using the req/rdy/valid protocol. Adds byte/half/word/(dword) accesses, byte enables, store lane steering, load sign/zero extension, misalignment detection and a bus timeout. A registered FSM drives the protocol; a stall output freezes the pipeline while an access is in flight.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data bus width; 32 or 64
TIMEOUT_CYC, 64, max cycles in REQ+WAIT before abort; 0 disables

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req  in  1  memory instruction in EX/MEM stage
we_in  in  1  1=store, 0=load
size  in  2  0=byte, 1=half, 2=word, 3=dword (legal only if DATA_W=64)
unsigned_ld  in  1  1=zero-extend load (LBU/LHU/LWU)
ADDR_IN  in  ADDR_W  byte address from ALU
WRITE_DATA  in  DATA_W  store data, right-aligned
wrAddr  in  5  load destination register
mem_rdy  in  1  memory accepts request this cycle
valid  in  1  memory completes access this cycle
rdata  in  DATA_W  read data, meaningful when valid
proc_req  out  1  request to memory
we  out  1  write enable to memory
addr  out  ADDR_W  bus-aligned address
wdata  out  DATA_W  lane-steered store data
be  out  DATA_W/8  byte enables
loadData  out  DATA_W  formatted load result
loadDest  out  5  register index for loadData
load_wen  out  1  one-cycle register-file write strobe
stall  out  1  hold pipeline
misaligned  out  1  one-cycle misaligned/illegal-size flag
timeout_err  out  1  one-cycle timeout flag

Behaviour:
- OFF = log2(DATA_W/8) low address bits. Aligned: byte always; half OFF[0]=0; word OFF[1:0]=0; dword OFF=0 and DATA_W=64. size=3 with DATA_W=32 is illegal -> misaligned.
- States IDLE, REQ, WAIT, DONE, ERR. Reset: state IDLE; all outputs 0; timeout counter 0.
- IDLE: req&aligned -> REQ, latching addr (ADDR_IN with OFF cleared), we, be, wdata, size, unsigned_ld, OFF, wrAddr. req&!aligned -> ERR, no bus request. Else stay.
- REQ: proc_req=1, addr/we/wdata/be held stable. proc_req&mem_rdy -> WAIT. valid ignored in REQ.
- WAIT: proc_req=0. valid -> DONE; on that edge capture formatted rdata into loadData, wrAddr into loadDest (loads only; stores leave loadData unchanged).
- DONE: load_wen=!we for exactly one cycle; -> IDLE. req in DONE is ignored (it is the same, just-released instruction).
- ERR: misaligned or timeout_err high one cycle (whichever caused entry); -> IDLE.
- stall = (IDLE & req) | REQ | WAIT. Low in DONE and ERR so the pipeline advances once.
- Minimum load latency: req@c0, handshake@c1, valid@c2, load_wen@c3; stall high c0..c2.
- Timeout: counter clears in IDLE, increments each REQ/WAIT cycle; reaching TIMEOUT_CYC -> ERR with timeout_err=1, proc_req drops immediately. Late valid after abort is ignored in IDLE.
- Store steering: wdata = WRITE_DATA low bytes shifted left by OFF*8 (bytes outside mask are don't-care, driven as replicated data); be = ((1<<2^size)-1)<<OFF.
- Load format: rdata>>(OFF*8), truncated to 2^size bytes, sign-extended unless unsigned_ld; full-width load passes through.
- Synchronous reset in any state returns to IDLE next edge; proc_req, stall, flags drop; in-flight response discarded.
- addr/we/wdata/be hold their last values outside REQ (no latches).

Decomposition:
- Package lsu_pkg: state enum, size encoding constants (SZ_B/SZ_H/SZ_W/SZ_D), aligned_f function.
- Sub-module lsu_align: combinational store steering/byte enables and load extraction/extension, parametrised on DATA_W.

Test Plan:
- LW addr 0x104, mem_rdy@c1, valid@c2, rdata=0xDEADBEEF, wrAddr=5 -> load_wen@c3, loadData=0xDEADBEEF, loadDest=5, stall c0..c2.
- LB addr 0x103, rdata=0x80FFFFFF -> loadData=0xFFFFFF80; LBU same -> 0x00000080; LH addr 0x102 rdata=0x8001xxxx -> 0xFFFF8001.
- SH addr 0x202 data 0x1234 -> addr=0x200, be=0b1100, wdata[31:16]=0x1234, we=1, load_wen stays 0 in DONE.
- LW addr 0x101 -> no proc_req, misaligned pulse next cycle, stall high one cycle only; size=3 with DATA_W=32 -> same.
- mem_rdy low 5 cycles, TIMEOUT_CYC=4 -> proc_req drops, timeout_err pulses, later valid ignored.
- rst asserted in WAIT -> next edge IDLE, all outputs 0; following LW completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: FSM states, access-size
// encodings and the alignment rule.
package lsu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DONE,
        ST_ERR
    } lsu_state_e;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    // off is the in-bus byte offset, zero-extended to 3 bits; dword needs a 64-bit bus
    function automatic logic aligned_f(input logic [1:0] sz, input logic [2:0] off,
                                       input int data_w);
        case (sz)
            SZ_B:    return 1'b1;
            SZ_H:    return ~off[0];
            SZ_W:    return off[1:0] == 2'b00;
            default: return (data_w == 64) && (off == 3'b000);
        endcase
    endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Data-memory port of the load/store unit (req/rdy/valid handshake).
interface lsu_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  proc_req;
    logic                  we;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   be;
    logic                  mem_rdy;
    logic                  valid;
    logic [DATA_W-1:0]     rdata;

    modport master (
        output proc_req, we, addr, wdata, be,
        input  mem_rdy, valid, rdata
    );

    modport slave (
        input  proc_req, we, addr, wdata, be,
        output mem_rdy, valid, rdata
    );
endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering for stores and extraction/extension for loads.
// Purely combinational; sized by the data bus width.
module lsu_align
    import lsu_pkg::*;
#(
    parameter  int DATA_W = 32,
    localparam int NB     = DATA_W / 8,
    localparam int OFF_W  = $clog2(NB)
) (
    input  logic [1:0]        st_size,
    input  logic [OFF_W-1:0]  st_off,
    input  logic [DATA_W-1:0] st_data,
    output logic [DATA_W-1:0] st_wdata,
    output logic [NB-1:0]     st_be,

    input  logic [1:0]        ld_size,
    input  logic [OFF_W-1:0]  ld_off,
    input  logic              ld_unsigned,
    input  logic [DATA_W-1:0] ld_rdata,
    output logic [DATA_W-1:0] ld_data
);

    // Replicating the low bytes across the bus lands them on any aligned offset.
    always_comb begin
        st_wdata = st_data;
        st_be    = '1;
        case (st_size)
            SZ_B: begin
                st_wdata = {NB{st_data[7:0]}};
                st_be    = NB'(1) << st_off;
            end
            SZ_H: begin
                st_wdata = {(NB/2){st_data[15:0]}};
                st_be    = NB'(3) << st_off;
            end
            SZ_W: begin
                st_wdata = {(NB/4){st_data[31:0]}};
                st_be    = NB'(15) << st_off;
            end
            default: begin
                st_wdata = st_data;
                st_be    = '1;
            end
        endcase
    end

    logic [DATA_W-1:0] sh;
    logic [DATA_W-1:0] keep;
    logic              msb;

    always_comb begin
        sh   = ld_rdata >> {ld_off, 3'b000};
        keep = '1;
        msb  = sh[DATA_W-1];
        case (ld_size)
            SZ_B: begin keep = DATA_W'(8'hFF);          msb = sh[7];  end
            SZ_H: begin keep = DATA_W'(16'hFFFF);       msb = sh[15]; end
            SZ_W: begin keep = DATA_W'(32'hFFFF_FFFF);  msb = sh[31]; end
            default: begin keep = '1;                   msb = sh[DATA_W-1]; end
        endcase
        ld_data = (sh & keep) | (~keep & {DATA_W{msb & ~ld_unsigned}});
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit FSM: latches an EX/MEM access, runs the memory handshake,
// formats load results and flags misalignment or bus timeout.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we_in,
    input  logic [1:0]        size,
    input  logic              unsigned_ld,
    input  logic [ADDR_W-1:0] ADDR_IN,
    input  logic [DATA_W-1:0] WRITE_DATA,
    input  logic [4:0]        wrAddr,
    lsu_ctrl_if.master        bus,
    output logic [DATA_W-1:0] loadData,
    output logic [4:0]        loadDest,
    output logic              load_wen,
    output logic              stall,
    output logic              misaligned,
    output logic              timeout_err
);

    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int TC_W  = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
    localparam logic [TC_W-1:0] TMO_LAST = TC_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    lsu_state_e        state;
    logic              proc_req_q, we_q, busy_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [NB-1:0]     be_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic [OFF_W-1:0]  off_q;
    logic [4:0]        dest_q;
    logic [TC_W-1:0]   tmo_cnt;

    logic [OFF_W-1:0]  off_in;
    logic              is_aligned, tmo_hit;
    logic [DATA_W-1:0] st_wdata, ld_data;
    logic [NB-1:0]     st_be;

    assign off_in     = ADDR_IN[OFF_W-1:0];
    assign is_aligned = aligned_f(size, 3'(off_in), DATA_W);
    assign tmo_hit    = (TIMEOUT_CYC != 0) && (tmo_cnt == TMO_LAST);

    lsu_align #(.DATA_W(DATA_W)) u_align (
        .st_size     (size),
        .st_off      (off_in),
        .st_data     (WRITE_DATA),
        .st_wdata    (st_wdata),
        .st_be       (st_be),
        .ld_size     (size_q),
        .ld_off      (off_q),
        .ld_unsigned (uns_q),
        .ld_rdata    (bus.rdata),
        .ld_data     (ld_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            proc_req_q  <= 1'b0;
            we_q        <= 1'b0;
            busy_q      <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            size_q      <= SZ_B;
            uns_q       <= 1'b0;
            off_q       <= '0;
            dest_q      <= '0;
            tmo_cnt     <= '0;
            loadData    <= '0;
            loadDest    <= '0;
            load_wen    <= 1'b0;
            misaligned  <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            load_wen    <= 1'b0;
            misaligned  <= 1'b0;
            timeout_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    tmo_cnt <= '0;
                    if (req && is_aligned) begin
                        state      <= ST_REQ;
                        proc_req_q <= 1'b1;
                        busy_q     <= 1'b1;
                        addr_q     <= {ADDR_IN[ADDR_W-1:OFF_W], OFF_W'(0)};
                        we_q       <= we_in;
                        wdata_q    <= st_wdata;
                        be_q       <= st_be;
                        size_q     <= size;
                        uns_q      <= unsigned_ld;
                        off_q      <= off_in;
                        dest_q     <= wrAddr;
                    end else if (req) begin
                        state      <= ST_ERR;
                        misaligned <= 1'b1;
                    end
                end
                ST_REQ: begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                    // An expiring budget wins even over a same-cycle handshake.
                    if (tmo_hit) begin
                        state       <= ST_ERR;
                        proc_req_q  <= 1'b0;
                        busy_q      <= 1'b0;
                        timeout_err <= 1'b1;
                    end else if (bus.mem_rdy) begin
                        state      <= ST_WAIT;
                        proc_req_q <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                    if (bus.valid) begin
                        state    <= ST_DONE;
                        busy_q   <= 1'b0;
                        load_wen <= ~we_q;
                        if (!we_q) begin
                            loadData <= ld_data;
                            loadDest <= dest_q;
                        end
                    end else if (tmo_hit) begin
                        state       <= ST_ERR;
                        busy_q      <= 1'b0;
                        timeout_err <= 1'b1;
                    end
                end
                // req seen here is the instruction just released; let it go.
                ST_DONE: state <= ST_IDLE;
                ST_ERR:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign stall        = busy_q | ((state == ST_IDLE) & req);
    assign bus.proc_req = proc_req_q;
    assign bus.we       = we_q;
    assign bus.addr     = addr_q;
    assign bus.wdata    = wdata_q;
    assign bus.be       = be_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scenario bench for lsu_ctrl; load results are checked through a scoreboard queue.
module tb_lsu_ctrl;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst, req, we_in, unsigned_ld;
    logic [1:0]  size;
    logic [31:0] ADDR_IN, WRITE_DATA, loadData;
    logic [4:0]  wrAddr, loadDest;
    logic        load_wen, stall, misaligned, timeout_err;

    int checks = 0;
    int errors = 0;
    logic [36:0] sb_q[$];

    lsu_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    lsu_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(4)) dut (
        .clk(clk), .rst(rst), .req(req), .we_in(we_in), .size(size),
        .unsigned_ld(unsigned_ld), .ADDR_IN(ADDR_IN), .WRITE_DATA(WRITE_DATA),
        .wrAddr(wrAddr), .bus(bus), .loadData(loadData), .loadDest(loadDest),
        .load_wen(load_wen), .stall(stall), .misaligned(misaligned),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (load_wen) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL load_unexpected got dest=%0d data=%h required no load", loadDest, loadData);
            end else begin
                logic [36:0] exp;
                exp = sb_q.pop_front();
                if ({loadDest, loadData} !== exp) begin
                    errors++;
                    $display("FAIL load_result got dest=%0d data=%h required dest=%0d data=%h",
                             loadDest, loadData, exp[36:32], exp[31:0]);
                end
            end
        end
    end

    logic [4:0]  o_st, o_pr, o_lw;
    logic [31:0] o_addr, o_wdata;
    logic [3:0]  o_be;
    logic        o_we;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Drives one access with an immediate handshake and a next-cycle response,
    // recording stall/proc_req/load_wen over five cycles and the bus at the handshake.
    task automatic issue(input logic w, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic [4:0] dst, input logic [31:0] rd);
        for (int c = 0; c < 5; c++) begin
            cyc();
            case (c)
                0: begin
                    req = 1'b1; we_in = w; size = sz; unsigned_ld = uns;
                    ADDR_IN = a; WRITE_DATA = d; wrAddr = dst;
                    bus.mem_rdy = 1'b0; bus.valid = 1'b0;
                end
                1: bus.mem_rdy = 1'b1;
                2: begin bus.mem_rdy = 1'b0; bus.valid = 1'b1; bus.rdata = rd; end
                3: bus.valid = 1'b0;
                default: req = 1'b0;
            endcase
            @(negedge clk);
            o_st[c] = stall; o_pr[c] = bus.proc_req; o_lw[c] = load_wen;
            if (c == 1) begin
                o_addr = bus.addr; o_wdata = bus.wdata; o_be = bus.be; o_we = bus.we;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 1'b0; we_in = 1'b0; size = SZ_B; unsigned_ld = 1'b0;
        ADDR_IN = '0; WRITE_DATA = '0; wrAddr = '0;
        bus.mem_rdy = 1'b0; bus.valid = 1'b0; bus.rdata = '0;
        repeat (2) cyc();
        @(negedge clk);
        checks++;
        if ({bus.proc_req, bus.we, stall, load_wen, misaligned, timeout_err} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags got %b required 000000",
                     {bus.proc_req, bus.we, stall, load_wen, misaligned, timeout_err});
        end
        checks++;
        if ({bus.addr, bus.be, loadData, loadDest} !== '0) begin
            errors++;
            $display("FAIL reset_regs got addr=%h be=%b ld=%h dest=%0d required zeros",
                     bus.addr, bus.be, loadData, loadDest);
        end
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_lw();
        sb_q.push_back({5'd5, 32'hDEAD_BEEF});
        issue(1'b0, SZ_W, 1'b0, 32'h104, 32'h0, 5'd5, 32'hDEAD_BEEF);
        checks++;
        if (o_st !== 5'b00111) begin errors++; $display("FAIL lw_stall got %b required 00111", o_st); end
        checks++;
        if (o_pr !== 5'b00010) begin errors++; $display("FAIL lw_proc_req got %b required 00010", o_pr); end
        checks++;
        if (o_lw !== 5'b01000) begin errors++; $display("FAIL lw_load_wen got %b required 01000", o_lw); end
        checks++;
        if ({o_addr, o_be, o_we} !== {32'h104, 4'hF, 1'b0}) begin
            errors++;
            $display("FAIL lw_bus got addr=%h be=%b we=%b required addr=104 be=1111 we=0", o_addr, o_be, o_we);
        end
    endtask

    typedef struct {
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] a, rd, ex;
    } ld_vec_t;

    task automatic test_load_ext();
        ld_vec_t v[7];
        v[0] = '{SZ_B, 1'b0, 32'h103, 32'h80FF_FFFF, 32'hFFFF_FF80};
        v[1] = '{SZ_B, 1'b1, 32'h103, 32'h80FF_FFFF, 32'h0000_0080};
        v[2] = '{SZ_H, 1'b0, 32'h102, 32'h8001_5A5A, 32'hFFFF_8001};
        v[3] = '{SZ_H, 1'b1, 32'h100, 32'h1234_F00D, 32'h0000_F00D};
        v[4] = '{SZ_B, 1'b0, 32'h100, 32'hAAAA_AA7F, 32'h0000_007F};
        v[5] = '{SZ_B, 1'b1, 32'h102, 32'h00C3_0000, 32'h0000_00C3};
        v[6] = '{SZ_H, 1'b0, 32'h100, 32'h0000_8000, 32'hFFFF_8000};
        for (int i = 0; i < 7; i++) begin
            sb_q.push_back({5'(10 + i), v[i].ex});
            issue(1'b0, v[i].sz, v[i].uns, v[i].a, 32'h0, 5'(10 + i), v[i].rd);
            checks++;
            if ({o_lw, o_addr} !== {5'b01000, v[i].a & 32'hFFFF_FFFC}) begin
                errors++;
                $display("FAIL ldext_%0d got lw=%b addr=%h required lw=01000 addr=%h",
                         i, o_lw, o_addr, v[i].a & 32'hFFFF_FFFC);
            end
        end
    endtask

    typedef struct {
        logic [1:0]  sz;
        logic [31:0] a, d, ea, mask, ed;
        logic [3:0]  ebe;
    } st_vec_t;

    task automatic test_store();
        st_vec_t v[4];
        v[0] = '{SZ_H, 32'h202, 32'hFFFF_1234, 32'h200, 32'hFFFF_0000, 32'h1234_0000, 4'b1100};
        v[1] = '{SZ_B, 32'h201, 32'h0000_00AB, 32'h200, 32'h0000_FF00, 32'h0000_AB00, 4'b0010};
        v[2] = '{SZ_W, 32'h300, 32'hCAFE_F00D, 32'h300, 32'hFFFF_FFFF, 32'hCAFE_F00D, 4'b1111};
        v[3] = '{SZ_B, 32'h307, 32'h1234_565C, 32'h304, 32'hFF00_0000, 32'h5C00_0000, 4'b1000};
        for (int i = 0; i < 4; i++) begin
            issue(1'b1, v[i].sz, 1'b0, v[i].a, v[i].d, 5'd1, 32'h0);
            checks++;
            if ({o_addr, o_be, o_we} !== {v[i].ea, v[i].ebe, 1'b1}) begin
                errors++;
                $display("FAIL st_bus_%0d got addr=%h be=%b we=%b required addr=%h be=%b we=1",
                         i, o_addr, o_be, o_we, v[i].ea, v[i].ebe);
            end
            checks++;
            if ((o_wdata & v[i].mask) !== v[i].ed) begin
                errors++;
                $display("FAIL st_wdata_%0d got %h required %h", i, o_wdata & v[i].mask, v[i].ed);
            end
            checks++;
            if ({o_lw, o_pr, o_st} !== {5'b00000, 5'b00010, 5'b00111}) begin
                errors++;
                $display("FAIL st_ctrl_%0d got lw=%b pr=%b st=%b required 00000 00010 00111",
                         i, o_lw, o_pr, o_st);
            end
        end
    endtask

    task automatic test_misaligned();
        logic [1:0]  sz[4];
        logic [31:0] a[4];
        logic [2:0]  s, p, m, t;
        sz[0] = SZ_W; a[0] = 32'h101;
        sz[1] = SZ_D; a[1] = 32'h100;
        sz[2] = SZ_H; a[2] = 32'h103;
        sz[3] = SZ_W; a[3] = 32'h102;
        for (int i = 0; i < 4; i++) begin
            for (int c = 0; c < 3; c++) begin
                cyc();
                if (c == 0) begin
                    req = 1'b1; we_in = 1'b0; size = sz[i]; unsigned_ld = 1'b0;
                    ADDR_IN = a[i]; wrAddr = 5'd2;
                end else begin
                    req = 1'b0;
                end
                @(negedge clk);
                s[c] = stall; p[c] = bus.proc_req; m[c] = misaligned; t[c] = timeout_err;
            end
            checks++;
            if ({m, s, p, t} !== {3'b010, 3'b001, 3'b000, 3'b000}) begin
                errors++;
                $display("FAIL misalign_%0d got mis=%b stall=%b preq=%b tmo=%b required 010 001 000 000",
                         i, m, s, p, t);
            end
        end
    endtask

    task automatic test_timeout();
        logic [7:0] pr, te, st, lw;
        for (int c = 0; c < 8; c++) begin
            cyc();
            case (c)
                0: begin
                    req = 1'b1; we_in = 1'b0; size = SZ_W; unsigned_ld = 1'b0;
                    ADDR_IN = 32'h400; wrAddr = 5'd3; bus.mem_rdy = 1'b0;
                end
                5: req = 1'b0;
                6: begin bus.valid = 1'b1; bus.rdata = 32'h1111_1111; end
                7: bus.valid = 1'b0;
                default: ;
            endcase
            @(negedge clk);
            pr[c] = bus.proc_req; te[c] = timeout_err; st[c] = stall; lw[c] = load_wen;
        end
        checks++;
        if (pr !== 8'b0001_1110) begin errors++; $display("FAIL tmo_proc_req got %b required 00011110", pr); end
        checks++;
        if (te !== 8'b0010_0000) begin errors++; $display("FAIL tmo_flag got %b required 00100000", te); end
        checks++;
        if (st !== 8'b0001_1111) begin errors++; $display("FAIL tmo_stall got %b required 00011111", st); end
        checks++;
        if (lw !== 8'b0) begin errors++; $display("FAIL tmo_late_valid got %b required 00000000", lw); end
    endtask

    task automatic test_rst_wait();
        cyc();
        req = 1'b1; we_in = 1'b0; size = SZ_W; unsigned_ld = 1'b0;
        ADDR_IN = 32'h500; wrAddr = 5'd7;
        cyc();
        bus.mem_rdy = 1'b1;
        cyc();
        bus.mem_rdy = 1'b0; rst = 1'b1; req = 1'b0;
        cyc();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.proc_req, stall, load_wen, bus.be, bus.addr, loadData, loadDest} !== '0) begin
            errors++;
            $display("FAIL rst_wait got preq=%b stall=%b lw=%b be=%b addr=%h ld=%h dest=%0d required zeros",
                     bus.proc_req, stall, load_wen, bus.be, bus.addr, loadData, loadDest);
        end
        cyc();
        bus.valid = 1'b1; bus.rdata = 32'h2222_2222;
        cyc();
        bus.valid = 1'b0;
        @(negedge clk);
        checks++;
        if (load_wen !== 1'b0) begin errors++; $display("FAIL rst_stale_resp got %b required 0", load_wen); end
        sb_q.push_back({5'd9, 32'h0BAD_F00D});
        issue(1'b0, SZ_W, 1'b0, 32'h600, 32'h0, 5'd9, 32'h0BAD_F00D);
        checks++;
        if ({o_lw, o_st} !== {5'b01000, 5'b00111}) begin
            errors++;
            $display("FAIL rst_recover got lw=%b st=%b required 01000 00111", o_lw, o_st);
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_load_ext();
        test_store();
        test_misaligned();
        test_timeout();
        test_rst_wait();
        repeat (2) cyc();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain got %0d pending required 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no finish required finish");
        $fatal(1);
    end

endmodule
